// File: rtl/mmc1_pkg.sv
// mmc1_pkg: FSM state codes, MMC1 register indices and bus constants for the serial writer.
package mmc1_pkg;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RST_WR  = 3'd1;
    localparam logic [2:0] ST_RST_GAP = 3'd2;
    localparam logic [2:0] ST_BIT_WR  = 3'd3;
    localparam logic [2:0] ST_BIT_GAP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [1:0] MMC1_REG_CTRL = 2'd0;
    localparam logic [1:0] MMC1_REG_CHR0 = 2'd1;
    localparam logic [1:0] MMC1_REG_CHR1 = 2'd2;
    localparam logic [1:0] MMC1_REG_PRG  = 2'd3;
    localparam logic [7:0] MMC1_RESET_DATA = 8'h80;
    // A reset write forces PRG mode 3 in the MMC1 control register.
    localparam logic [4:0] MMC1_CTRL_RESET_OR = 5'b0_11_00;

    function automatic logic [15:0] mmc1_reg_addr(input logic [15:0] base, input logic [1:0] idx);
        return base | {1'b0, idx, 13'd0};
    endfunction
endpackage

// File: rtl/mmc1_shadow_regs.sv
// mmc1_shadow_regs: software-visible copy of the four MMC1 registers (built only with MMC1_WR_SHADOW_EN).
//  clk, reset_n   clock, async active-low reset
//  wr_en          load wr_data into register wr_idx (sequence completion)
//  wr_idx/wr_data register index and value
//  rst_or         reset write completed: OR PRG-mode bits into ctrl
//  ctrl/chr0/chr1/prg  shadow register values
`ifdef MMC1_WR_SHADOW_EN
module mmc1_shadow_regs
    import mmc1_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [1:0] wr_idx,
    input  logic [4:0] wr_data,
    input  logic       rst_or,
    output logic [4:0] ctrl,
    output logic [4:0] chr0,
    output logic [4:0] chr1,
    output logic [4:0] prg
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= MMC1_CTRL_RESET_OR;
            chr0 <= 5'd0;
            chr1 <= 5'd0;
            prg  <= 5'd0;
        end else begin
            ctrl <= wr_en && wr_idx == MMC1_REG_CTRL ? wr_data : rst_or ? ctrl | MMC1_CTRL_RESET_OR : ctrl;
            chr0 <= wr_en && wr_idx == MMC1_REG_CHR0 ? wr_data : chr0;
            chr1 <= wr_en && wr_idx == MMC1_REG_CHR1 ? wr_data : chr1;
            prg  <= wr_en && wr_idx == MMC1_REG_PRG  ? wr_data : prg;
        end
    end
endmodule
`endif

// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer: bus master that writes one MMC1 register through its 5-bit serial port, paced on M2.
//  Optional feature macro: MMC1_WR_SHADOW_EN adds shadow_ctrl/chr0/chr1/prg outputs.
//  clk, reset_n         clock, async active-low reset
//  ce                   M2 enable; every bus change happens on a ce edge
//  enable               low forces a return to IDLE with the bus quiet
//  req_valid/req_ready  request handshake (ready only in IDLE)
//  req_reg/req_data/req_rst  target register, 5-bit value (bit0 first), precede with reset write
//  prg_ain/prg_din/prg_write CPU address, data, write strobe (one ce period per write)
//  busy, done           sequence in progress, 1-clk completion pulse
module mmc1_serial_writer
    import mmc1_pkg::*;
#(
    parameter int unsigned GAP_CE    = 1,
    parameter logic [15:0] BASE_ADDR = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_reg,
    input  logic [4:0]  req_data,
    input  logic        req_rst,
    output logic [15:0] prg_ain,
    output logic [7:0]  prg_din,
    output logic        prg_write,
    output logic        busy,
    output logic        done
`ifdef MMC1_WR_SHADOW_EN
    ,
    output logic [4:0]  shadow_ctrl,
    output logic [4:0]  shadow_chr0,
    output logic [4:0]  shadow_chr1,
    output logic [4:0]  shadow_prg
`endif
);
    localparam logic [2:0] GAP_LAST = 3'(GAP_CE - 1);

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [2:0] gap_cnt;
    logic [1:0] reg_q;
    logic [4:0] data_q;
    logic [2:0] nxt_bit;
    logic [15:0] bit_addr;

    assign req_ready = state == ST_IDLE && enable;
    assign busy      = state != ST_IDLE;
    assign bit_addr  = mmc1_reg_addr(BASE_ADDR, reg_q);
    assign nxt_bit   = state == ST_RST_GAP ? 3'd0 : bit_cnt + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            gap_cnt   <= 3'd0;
            reg_q     <= 2'd0;
            data_q    <= 5'd0;
            prg_ain   <= BASE_ADDR;
            prg_din   <= 8'd0;
            prg_write <= 1'b0;
            done      <= 1'b0;
        end else if (!enable) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            gap_cnt   <= 3'd0;
            prg_write <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    reg_q   <= req_reg;
                    data_q  <= req_data;
                    bit_cnt <= 3'd0;
                    gap_cnt <= 3'd0;
                    state   <= req_rst ? ST_RST_WR : ST_BIT_WR;
                end
                // prg_write doubles as the sub-phase: low = waiting to strobe, high = strobe in progress.
                ST_RST_WR, ST_BIT_WR: if (ce) begin
                    prg_write <= !prg_write;
                    if (prg_write) begin
                        state <= state == ST_RST_WR ? ST_RST_GAP : ST_BIT_GAP;
                    end else begin
                        prg_ain <= state == ST_RST_WR ? BASE_ADDR : bit_addr;
                        prg_din <= state == ST_RST_WR ? MMC1_RESET_DATA : {7'd0, data_q[bit_cnt]};
                    end
                end
                // The last gap edge launches the next strobe directly, so the quiet time is exactly GAP_CE periods.
                ST_RST_GAP, ST_BIT_GAP: if (ce) begin
                    gap_cnt <= gap_cnt == GAP_LAST ? 3'd0 : gap_cnt + 3'd1;
                    if (gap_cnt == GAP_LAST) begin
                        if (state == ST_BIT_GAP && bit_cnt == 3'd4) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_BIT_WR;
                            bit_cnt   <= nxt_bit;
                            prg_write <= 1'b1;
                            prg_ain   <= bit_addr;
                            prg_din   <= {7'd0, data_q[nxt_bit]};
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MMC1_WR_SHADOW_EN
    mmc1_shadow_regs u_shadow (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (state == ST_DONE && enable),
        .wr_idx  (reg_q),
        .wr_data (data_q),
        .rst_or  (state == ST_RST_WR && ce && prg_write && enable),
        .ctrl    (shadow_ctrl),
        .chr0    (shadow_chr0),
        .chr1    (shadow_chr1),
        .prg     (shadow_prg)
    );
`endif
endmodule

// File: tb/tb_mmc1_serial_writer.sv
// tb_mmc1_serial_writer: random and directed requests against two writers (GAP_CE 1 and 3) driving a behavioural MMC1.
`timescale 1ns/1ps
module tb_mmc1_serial_writer;
    typedef struct {
        int          inst;
        logic [15:0] ain;
        logic [7:0]  din;
        int          ce;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        ce_on = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  req_reg = 2'd0;
    logic [4:0]  req_data = 5'd0;
    logic        req_rst = 1'b0;
    logic        rv   [2];
    logic        rdy  [2];
    logic        wr   [2];
    logic        busy [2];
    logic        done [2];
    logic [15:0] ain  [2];
    logic [7:0]  din  [2];
    logic [4:0]  sh   [8];

    int   n_chk = 0;
    int   n_err = 0;
    int   ce_cnt = 0;
    int   phase = 0;
    logic ce_edge = 1'b0;
    logic en_q = 1'b0;
    logic prev_wr [2];
    logic [4:0] mregs [2][4];
    logic [4:0] shf [2];
    int   scnt [2];
    int   drops [2];
    wr_t  logq [$];

    mmc1_serial_writer #(.GAP_CE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_reg(req_reg), .req_data(req_data), .req_rst(req_rst),
        .prg_ain(ain[0]), .prg_din(din[0]), .prg_write(wr[0]), .busy(busy[0]), .done(done[0])
`ifdef MMC1_WR_SHADOW_EN
        , .shadow_ctrl(sh[0]), .shadow_chr0(sh[1]), .shadow_chr1(sh[2]), .shadow_prg(sh[3])
`endif
    );

    mmc1_serial_writer #(.GAP_CE(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_reg(req_reg), .req_data(req_data), .req_rst(req_rst),
        .prg_ain(ain[1]), .prg_din(din[1]), .prg_write(wr[1]), .busy(busy[1]), .done(done[1])
`ifdef MMC1_WR_SHADOW_EN
        , .shadow_ctrl(sh[4]), .shadow_chr0(sh[5]), .shadow_chr1(sh[6]), .shadow_prg(sh[7])
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        phase = (phase + 1) % 4;
        ce = ce_on && phase == 0;
    end

    always @(posedge clk) begin
        ce_edge <= ce;
        en_q <= enable && reset_n;
        if (ce) ce_cnt <= ce_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural MMC1: serial shift on each sampled strobe, commit on the fifth bit, reset on bit 7.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!en_q) begin
                prev_wr[i] = wr[i];
            end else if (ce_edge) begin
                if (wr[i]) begin
                    wr_t w;
                    w.inst = i; w.ain = ain[i]; w.din = din[i]; w.ce = ce_cnt;
                    logq.push_back(w);
                    if (prev_wr[i]) drops[i]++;
                    else if (din[i][7]) begin
                        scnt[i] = 0;
                        mregs[i][0] = mregs[i][0] | 5'b0_11_00;
                    end else begin
                        shf[i] = {din[i][0], shf[i][4:1]};
                        scnt[i]++;
                        if (scnt[i] == 5) begin
                            mregs[i][ain[i][14:13]] = shf[i];
                            scnt[i] = 0;
                        end
                    end
                end
                prev_wr[i] = wr[i];
            end else begin
                chk("stall", 32'(wr[i]), 32'(prev_wr[i]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int nw_since(input int i, input int start);
        int n = 0;
        for (int k = start; k < logq.size(); k++) if (logq[k].inst == i) n++;
        return n;
    endfunction

    task automatic chk_reset(input int i);
        chk("rst_ready", 32'(rdy[i]), 1);
        chk("rst_ain", 32'(ain[i]), 32'h8000);
        chk("rst_din", 32'(din[i]), 0);
        chk("rst_write", 32'(wr[i]), 0);
        chk("rst_busy", 32'(busy[i]), 0);
        chk("rst_done", 32'(done[i]), 0);
`ifdef MMC1_WR_SHADOW_EN
        chk("rst_sh_ctrl", 32'(sh[i*4]), 32'h0C);
        for (int k = 1; k < 4; k++) chk("rst_sh", 32'(sh[i*4+k]), 0);
`endif
    endtask

    task automatic issue(input int i, input logic [1:0] r, input logic [4:0] d, input logic rs,
                         output int start, output int c0);
        int n = 0;
        while (!rdy[i] && n < 500) begin tick(); n++; end
        chk("ready_wait", 32'(rdy[i]), 1);
        start = logq.size();
        req_reg = r; req_data = d; req_rst = rs; rv[i] = 1'b1;
        tick();
        c0 = ce_cnt;
        chk("accept_busy", 32'(busy[i]), 1);
        chk("ready_low", 32'(rdy[i]), 0);
    endtask

    task automatic finish(input int i, input logic [1:0] r, input logic [4:0] d, input logic rs,
                          input int gap, input int start, input int c0);
        int n = 0;
        int off = rs ? 1 : 0;
        int nw = 5 + off;
        int done_ce;
        wr_t w [$];
        while (!done[i] && n < 4000) begin tick(); n++; end
        chk("done_seen", 32'(done[i]), 1);
        done_ce = ce_cnt;
        for (int k = start; k < logq.size(); k++) if (logq[k].inst == i) w.push_back(logq[k]);
        chk("n_writes", w.size(), nw);
        for (int k = 0; k < w.size() && k < nw; k++) begin
            chk("ain", 32'(w[k].ain), (rs && k == 0) ? 32'h8000 : 32'(16'h8000 | (16'(r) << 13)));
            chk("din", 32'(w[k].din), (rs && k == 0) ? 32'h80 : 32'(d[k-off]));
            if (k > 0) chk("spacing", w[k].ce - w[k-1].ce, 1 + gap);
        end
        if (w.size() > 0) begin
            chk("first_wr", w[0].ce, c0 + 1);
            chk("total_ce", done_ce - w[0].ce, (1 + gap) * nw);
        end
        chk("mmc1_reg", 32'(mregs[i][r]), 32'(d));
        chk("drops", drops[i], 0);
        tick();
        chk("ready_back", 32'(rdy[i]), 1);
        chk("done_pulse", 32'(done[i]), 0);
`ifdef MMC1_WR_SHADOW_EN
        for (int k = 0; k < 4; k++) chk("shadow", 32'(sh[i*4+k]), 32'(mregs[i][k]));
`endif
    endtask

    initial begin
        int st, c0, st2, c02, dn;
        logic [1:0] r;
        logic [4:0] d;
        logic rs;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; prev_wr[i] = 1'b0; shf[i] = 5'd0; scnt[i] = 0; drops[i] = 0;
            mregs[i][0] = 5'b0_11_00; mregs[i][1] = 5'd0; mregs[i][2] = 5'd0; mregs[i][3] = 5'd0;
        end
        repeat (3) tick();
        chk_reset(0);
        chk_reset(1);
        reset_n = 1'b1;
        repeat (3) tick();

        // prg_bank via $E000, no reset write
        issue(0, 2'd3, 5'b01010, 1'b0, st, c0); rv[0] = 1'b0;
        finish(0, 2'd3, 5'b01010, 1'b0, 1, st, c0);
        // control with leading reset write
        issue(0, 2'd0, 5'b10011, 1'b1, st, c0); rv[0] = 1'b0;
        finish(0, 2'd0, 5'b10011, 1'b1, 1, st, c0);
        // GAP_CE=3 instance
        issue(1, 2'd1, 5'b11111, 1'b0, st, c0); rv[1] = 1'b0;
        finish(1, 2'd1, 5'b11111, 1'b0, 3, st, c0);

        // second request held through the first
        issue(0, 2'd1, 5'b00110, 1'b0, st, c0);
        req_reg = 2'd2; req_data = 5'b11001; req_rst = 1'b0;
        repeat (10) begin tick(); chk("held_ready", 32'(rdy[0]), 0); end
        finish(0, 2'd1, 5'b00110, 1'b0, 1, st, c0);
        st2 = logq.size();
        tick();
        c02 = ce_cnt;
        chk("held_accept", 32'(busy[0]), 1);
        rv[0] = 1'b0;
        finish(0, 2'd2, 5'b11001, 1'b0, 1, st2, c02);

        // ce stopped mid-sequence
        issue(0, 2'd3, 5'b10110, 1'b0, st, c0); rv[0] = 1'b0;
        dn = 0;
        while (nw_since(0, st) < 2 && dn < 200) begin tick(); dn++; end
        ce_on = 1'b0;
        repeat (40) tick();
        chk("stall_busy", 32'(busy[0]), 1);
        ce_on = 1'b1;
        finish(0, 2'd3, 5'b10110, 1'b0, 1, st, c0);

        // enable dropped after the third bit write
        issue(0, 2'd2, 5'b11010, 1'b0, st, c0); rv[0] = 1'b0;
        dn = 0;
        while (nw_since(0, st) < 3 && dn < 200) begin tick(); dn++; end
        chk("three_writes", nw_since(0, st), 3);
        enable = 1'b0;
        tick();
        chk("en_write", 32'(wr[0]), 0);
        chk("en_busy", 32'(busy[0]), 0);
        dn = 0;
        repeat (20) begin tick(); if (done[0]) dn++; end
        chk("en_no_done", dn, 0);
        enable = 1'b1;
        issue(0, 2'd2, 5'b00101, 1'b1, st, c0); rv[0] = 1'b0;
        finish(0, 2'd2, 5'b00101, 1'b1, 1, st, c0);

        // random traffic
        for (int t = 0; t < 10; t++) begin
            int i = t >= 8 ? 1 : 0;
            r = 2'($urandom_range(0, 3));
            d = 5'($urandom);
            rs = 1'($urandom);
            issue(i, r, d, rs, st, c0); rv[i] = 1'b0;
            finish(i, r, d, rs, i == 1 ? 3 : 1, st, c0);
        end

        // asynchronous reset during a bit gap
        issue(0, 2'd1, 5'b01101, 1'b0, st, c0); rv[0] = 1'b0;
        dn = 0;
        while (!(nw_since(0, st) >= 2 && !wr[0]) && dn < 200) begin tick(); dn++; end
        chk("gap_reached", 32'(busy[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_busy", 32'(busy[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
